// File: rtl/squ_ctrl_pkg.sv
// Shared control definitions for the squ datapath burst scheduler.
package squ_ctrl_pkg;

   localparam int SQU_W    = 5;
   localparam int SQU_NREQ = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/squ_rr_arbiter.sv
// Two-way round-robin pick; purely combinational.
module squ_rr_arbiter
   import squ_ctrl_pkg::*;
(
   input  logic [SQU_NREQ-1:0] valid,
   input  logic                last_grant,
   output logic                gnt_id,
   output logic                gnt_any
);

   always_comb begin
      gnt_any = |valid;
      if (&valid) gnt_id = ~last_grant;
      else        gnt_id = valid[1];
   end

endmodule

// File: rtl/squ_burst_scheduler.sv
// Burst scheduler: grants the serial datapath to one requester per job,
// streams BURST_LEN words and collects one result bit per word.
module squ_burst_scheduler
   import squ_ctrl_pkg::*;
#(
   parameter int BURST_LEN = 8,
   parameter int DP_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   input  logic                 req1_valid,
   input  logic [SQU_W-1:0]     req0_data,
   input  logic [SQU_W-1:0]     req1_data,
   output logic                 req0_ready,
   output logic                 req1_ready,
   output logic                 dp_clr,
   output logic                 dp_en,
   output logic [SQU_W-1:0]     dp_d_in,
   input  logic                 dp_d_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [BURST_LEN-1:0] rsp_data,
   output logic                 busy
);

   localparam int CW = $clog2(BURST_LEN + 1);

   state_t            state, state_nx;
   logic              gnt_q, last_grant;
   logic              gnt_id, gnt_any;
   logic              hs, smp, done;
   logic [CW-1:0]     word_cnt, sample_cnt;
   logic [DP_LAT-1:0] en_dly;

   squ_rr_arbiter u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .gnt_id     (gnt_id),
      .gnt_any    (gnt_any)
   );

   assign hs   = (state == ST_STREAM) & (gnt_q ? req1_valid : req0_valid);
   assign smp  = en_dly[DP_LAT-1];
   // The final sample may land in the same cycle DRAIN checks for completion
   assign done = (sample_cnt == CW'(BURST_LEN))
               | (smp & (sample_cnt == CW'(BURST_LEN - 1)));

   assign req0_ready = (state == ST_STREAM) & ~gnt_q;
   assign req1_ready = (state == ST_STREAM) & gnt_q;
   assign dp_clr     = (state == ST_CLEAR);
   assign busy       = (state != ST_IDLE);
   assign rsp_id     = gnt_q;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (gnt_any) state_nx = ST_CLEAR;
         ST_CLEAR:  state_nx = ST_STREAM;
         ST_STREAM: if (hs && word_cnt == CW'(BURST_LEN - 1)) state_nx = ST_DRAIN;
         ST_DRAIN:  if (done) state_nx = ST_RESP;
         ST_RESP:   if (rsp_ready) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q      <= 1'b0;
         last_grant <= 1'b1;
         dp_en      <= 1'b0;
         dp_d_in    <= '0;
         en_dly     <= '0;
         word_cnt   <= '0;
         sample_cnt <= '0;
         rsp_data   <= '0;
         rsp_valid  <= 1'b0;
      end else begin
         dp_en     <= hs;
         en_dly[0] <= dp_en;
         for (int i = 1; i < DP_LAT; i++) en_dly[i] <= en_dly[i-1];
         rsp_valid <= (state_nx == ST_RESP);

         if (state == ST_IDLE) begin
            dp_d_in <= '0;
            if (gnt_any) gnt_q <= gnt_id;
         end

         if (hs) begin
            dp_d_in  <= gnt_q ? req1_data : req0_data;
            word_cnt <= word_cnt + CW'(1);
         end

         if (state == ST_CLEAR) begin
            word_cnt   <= '0;
            sample_cnt <= '0;
            rsp_data   <= '0;
         end else if (smp) begin
            sample_cnt <= sample_cnt + CW'(1);
            for (int i = 0; i < BURST_LEN; i++)
               if (sample_cnt == CW'(i)) rsp_data[i] <= dp_d_out;
         end

         if (state == ST_RESP && rsp_ready) last_grant <= gnt_q;
      end
   end

endmodule

// File: tb/tb_squ_burst_scheduler.sv
// Directed/random bench for squ_burst_scheduler against a parity datapath stub.
module tb_squ_burst_scheduler;

   localparam int BL = 8;

   logic       clk, reset, hold2, reset2;
   logic       req0_valid, req1_valid;
   logic [4:0] req0_data, req1_data;
   logic       req0_ready, req1_ready, dp_clr, dp_en, dp_d_out;
   logic [4:0] dp_d_in;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_data;

   logic       req0_ready2, req1_ready2, dp_clr2, dp_en2, dp_d_out2;
   logic [4:0] dp_d_in2;
   logic       rsp_valid2, rsp_ready2, rsp_id2, busy2;
   logic [7:0] rsp_data2;

   logic       s1, t0r, t1r, t2r;

   squ_burst_scheduler #(.BURST_LEN(BL), .DP_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_data(req0_data), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .dp_clr(dp_clr), .dp_en(dp_en), .dp_d_in(dp_d_in),
      .dp_d_out(dp_d_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   squ_burst_scheduler #(.BURST_LEN(BL), .DP_LAT(3)) dut3 (
      .clk(clk), .reset(reset2),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_data(req0_data), .req1_data(req1_data),
      .req0_ready(req0_ready2), .req1_ready(req1_ready2),
      .dp_clr(dp_clr2), .dp_en(dp_en2), .dp_d_in(dp_d_in2),
      .dp_d_out(dp_d_out2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
      .rsp_id(rsp_id2), .rsp_data(rsp_data2), .busy(busy2)
   );

   assign reset2 = reset | hold2;

   // Datapath stubs: parity of the word from the previous dp_en cycle.
   always @(posedge clk) begin
      if (reset || dp_clr) s1 <= 1'b0;
      else if (dp_en)      s1 <= ^dp_d_in;
   end
   assign dp_d_out = s1;

   always @(posedge clk) begin
      if (reset2 || dp_clr2) t0r <= 1'b0;
      else if (dp_en2)       t0r <= ^dp_d_in2;
      t1r <= t0r;
      t2r <= t1r;
   end
   assign dp_d_out2 = t2r;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [4:0] q0[$], q1[$];
   int pop0, bub_at, bub_left;
   int clr_cnt, clr_cyc, en_cnt, en_first, en_last;
   logic saw0, saw1;
   int first2;
   logic [7:0] data2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] parity_vec(input logic [4:0] w[8]);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = ^w[i];
      return r;
   endfunction

   function automatic logic [31:0] outs();
      return {12'd0, req0_ready, req1_ready, dp_clr, dp_en, dp_d_in,
              rsp_valid, rsp_id, rsp_data, busy};
   endfunction

   task automatic drive();
      if (bub_left > 0 && pop0 == bub_at) req0_valid = 1'b0;
      else                                req0_valid = (q0.size() > 0);
      req0_data  = (q0.size() > 0) ? q0[0] : 5'd0;
      req1_valid = (q1.size() > 0);
      req1_data  = (q1.size() > 0) ? q1[0] : 5'd0;
   endtask

   task automatic clr_log();
      clr_cnt = 0; clr_cyc = -1;
      en_cnt = 0; en_first = -1; en_last = -1;
      saw0 = 1'b0; saw1 = 1'b0;
      pop0 = 0; first2 = -1;
   endtask

   task automatic tick();
      logic h0, h1;
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      if (dp_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (dp_en) begin
         en_cnt++;
         if (en_first < 0) en_first = cyc;
         en_last = cyc;
      end
      if (req0_ready) saw0 = 1'b1;
      if (req1_ready) saw1 = 1'b1;
      if (rsp_valid && rsp_ready) begin saw0 = 1'b0; saw1 = 1'b0; end
      if (rsp_valid2 && first2 < 0) begin first2 = cyc; data2 = rsp_data2; end
      if (!req0_valid && bub_left > 0 && pop0 == bub_at) bub_left--;
      chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 0);
      @(posedge clk);
      #1;
      cyc++;
      if (h0) begin void'(q0.pop_front()); pop0++; end
      if (h1) void'(q1.pop_front());
      drive();
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 200) begin tick(); n++; end
      chk("rsp_timeout", {31'd0, rsp_valid}, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete(); q1.delete();
      bub_left = 0; pop0 = 0;
      drive();
      tick(); tick();
      reset = 1'b0;
   endtask

   logic [4:0] fw[8] = '{5'b10001, 5'b01010, 5'b11100, 5'b00110,
                         5'b10101, 5'b01110, 5'b00000, 5'b11011};
   logic [4:0] jw[8];
   logic [4:0] w0[16], w1[16];
   logic [7:0] exp_d;
   int t0, r_cyc, i0, i1;
   logic lg, g;

   initial begin
      reset = 1'b1; hold2 = 1'b1; rsp_ready = 1'b1; rsp_ready2 = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
      bub_at = -1; bub_left = 0; pop0 = 0;
      @(posedge clk); #1;
      clr_log();
      tick(); tick();
      reset = 1'b0;
      chk("reset_outputs", outs(), 0);

      // Reset in the middle of a burst, then a clean req0 job
      for (int i = 0; i < 8; i++) q0.push_back(5'($urandom_range(31, 0)));
      drive();
      for (int i = 0; i < 5; i++) tick();
      chk("mid_stream_busy", {31'd0, busy}, 1);
      reset = 1'b1;
      tick();
      chk("mid_reset_outputs", outs(), 0);
      reset = 1'b0;
      q0.delete();
      clr_log();
      for (int i = 0; i < 8; i++) jw[i] = 5'($urandom_range(31, 0));
      for (int i = 0; i < 8; i++) q0.push_back(jw[i]);
      drive();
      t0 = cyc;
      wait_rsp();
      chk("post_reset_lat", cyc - t0, BL + 4);
      chk("post_reset_data", {24'd0, rsp_data}, {24'd0, parity_vec(jw)});
      chk("post_reset_id", {31'd0, rsp_id}, 0);
      tick();
      chk("post_reset_idle", {31'd0, busy}, 0);

      // Fixed words on both latency builds
      hold2 = 1'b0;
      clr_log();
      for (int i = 0; i < 8; i++) q0.push_back(fw[i]);
      drive();
      t0 = cyc;
      wait_rsp();
      chk("single_lat", cyc - t0, 12);
      chk("single_data", {24'd0, rsp_data}, 32'h34);
      chk("single_id", {31'd0, rsp_id}, 0);
      chk("single_clr_cnt", clr_cnt, 1);
      chk("single_clr_cyc", clr_cyc - t0, 1);
      for (int i = 0; i < 6 && first2 < 0; i++) tick();
      chk("lat3_first", first2 - t0, 14);
      chk("lat3_data", {24'd0, data2}, 32'h34);
      hold2 = 1'b1;
      tick();

      // Three-cycle bubble after word 4
      clr_log();
      bub_at = 4; bub_left = 3;
      for (int i = 0; i < 8; i++) q0.push_back(fw[i]);
      drive();
      t0 = cyc;
      wait_rsp();
      chk("bubble_lat", cyc - t0, 15);
      chk("bubble_data", {24'd0, rsp_data}, 32'h34);
      chk("bubble_en_cnt", en_cnt, 8);
      chk("bubble_en_gap", en_last - en_first + 1 - en_cnt, 3);
      tick();
      bub_at = -1;

      // Response backpressure with req1 waiting
      clr_log();
      rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) jw[i] = 5'($urandom_range(31, 0));
      exp_d = parity_vec(jw);
      for (int i = 0; i < 8; i++) q0.push_back(jw[i]);
      drive();
      t0 = cyc;
      tick();
      for (int i = 0; i < 8; i++) jw[i] = 5'($urandom_range(31, 0));
      for (int i = 0; i < 8; i++) q1.push_back(jw[i]);
      drive();
      wait_rsp();
      chk("bp_lat", cyc - t0, 12);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 1);
         chk("bp_data", {24'd0, rsp_data}, {24'd0, exp_d});
         chk("bp_ready", {30'd0, req0_ready, req1_ready}, 0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_valid_last", {31'd0, rsp_valid}, 1);
      tick();
      chk("bp_idle", {31'd0, busy}, 0);
      t0 = cyc;
      wait_rsp();
      chk("bp_next_lat", cyc - t0, 12);
      chk("bp_next_id", {31'd0, rsp_id}, 1);
      chk("bp_next_data", {24'd0, rsp_data}, {24'd0, parity_vec(jw)});
      tick();

      // Round-robin with both requesters loaded from reset
      do_reset();
      clr_log();
      for (int i = 0; i < 16; i++) begin
         w0[i] = 5'($urandom_range(31, 0));
         w1[i] = 5'($urandom_range(31, 0));
         q0.push_back(w0[i]);
         q1.push_back(w1[i]);
      end
      drive();
      t0 = cyc;
      r_cyc = t0 - 1;
      i0 = 0; i1 = 0; lg = 1'b1;
      for (int j = 0; j < 4; j++) begin
         g = (i0 < 16 && i1 < 16) ? ~lg : (i1 < 16);
         for (int k = 0; k < 8; k++) jw[k] = g ? w1[i1 + k] : w0[i0 + k];
         if (g) i1 += 8; else i0 += 8;
         lg = g;
         wait_rsp();
         chk("rr_time", cyc, r_cyc + 1 + BL + 4);
         chk("rr_id", {31'd0, rsp_id}, {31'd0, g});
         chk("rr_data", {24'd0, rsp_data}, {24'd0, parity_vec(jw)});
         chk("rr_saw", {30'd0, saw0, saw1}, {30'd0, ~g, g});
         r_cyc = cyc;
         tick();
      end
      chk("rr_end_idle", {31'd0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
